mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles in MEM waiting for mem_ready before error (1..255).
REQ-002 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 instr  input  32  instruction word from instruction memory, valid during IF.
REQ-006 zero  input  1  ALU result-equals-zero flag, valid during EX.
REQ-007 lt  input  1  ALU signed less-than flag, valid during EX.
REQ-008 mem_ready  input  1  data-memory access complete, sampled in MEM.
REQ-009 MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg, loadPC, PCSrc  output  1 each  datapath controls.
REQ-010 ALUCtrl  output  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0100, XOR 0101, LSR 1000, LSL 1001, ASR 1010.
REQ-011 state  output  3  current state: IF 000, ID 001, EX 010, MEM 011, WB 100, ERR 101.
REQ-012 mem_err  output  1  sticky memory-timeout flag.
REQ-013 instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-014 Instruction register ir SHALL capture instr on the IF->ID edge; all decoding SHALL use ir, never live instr.
REQ-015 Transitions SHALL be IF->ID->EX; EX->MEM for opcodes 0000011 (LW) and 0100011 (SW); EX->WB otherwise; MEM->WB when mem_ready=1; WB->IF.
REQ-016 MEM SHALL hold while mem_ready=0; a wait counter SHALL reset on MEM entry and increment each waiting cycle; on reaching MEM_TIMEOUT with mem_ready=0, next state SHALL be ERR and mem_err SHALL set.
REQ-017 mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT SHALL win: go to WB, no error.
REQ-018 ERR SHALL be terminal until rst; all controls 0 in ERR.
REQ-019 ALUCtrl SHALL be decoded from ir in ID, EX, MEM and WB, and be 0000 in IF/ERR: LW/SW ADD; branch (1100011) SUB; R-type (0110011) by {funct7,funct3}; I-type (0010011) by funct3 with funct3=101 choosing LSR (funct7=0000000) or ASR (0100000); unlisted encodings AND.
REQ-020 ALUSrc SHALL be 1 in EX, MEM, WB for LW, SW, I-type; 0 otherwise.
REQ-021 Branch decision SHALL be registered at EX exit: funct3 000 taken if zero, 001 if !zero, 100 if lt, 101 if !lt, other funct3 not taken.
REQ-022 PCSrc SHALL equal the registered branch decision during WB only; 0 elsewhere.
REQ-023 MemRead (LW) / MemWrite (SW) SHALL be 1 throughout MEM, including wait cycles.
REQ-024 RegWrite SHALL be 1 in WB for LW, R-type, I-type; MemtoReg SHALL be 1 in EX, MEM, WB for LW.
REQ-025 loadPC SHALL be 1 exactly one cycle per instruction, in WB.
REQ-026 Unrecognised opcodes SHALL execute as NOP: IF->ID->EX->WB, loadPC=1, no writes, PCSrc=0.
REQ-027 CPI SHALL be 4 for non-memory instructions and 5+waits for LW/SW.

Reset
REQ-028 rst SHALL force, asynchronously, state=IF, ir=0, wait counter=0, branch flag=0, mem_err=0, instr_cnt=0; all controls 0 in IF.
REQ-029 rst asserted mid-instruction (any state incl. MEM wait) SHALL abort it with no further loadPC or write strobes.

Configuration
REQ-030 With macro MC_CTRL_PERF_CNT_EN defined, instr_cnt SHALL increment by 1 on every cycle with loadPC=1, wrapping from all-ones to 0.
REQ-031 Without MC_CTRL_PERF_CNT_EN, instr_cnt SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3): states 0,1,2,4,0; ALUCtrl=0010 from ID; RegWrite=1 and loadPC=1 only in WB.
REQ-033 LW (0x0000A183), mem_ready low 3 MEM cycles then high: MEM lasts 4 cycles, MemRead=1 throughout, RegWrite=MemtoReg=1 in WB, 8 cycles total.
REQ-034 BNE (funct3=001) with zero=0 in EX: PCSrc=1 in WB; repeat with zero=1: PCSrc=0; BLT with lt=1: PCSrc=1.
REQ-035 SW with mem_ready held 0, MEM_TIMEOUT=15: state=101 and mem_err=1 after 15 MEM cycles; all controls 0; only rst recovers.
REQ-036 rst pulsed during MEM wait of SW: state=000, MemWrite=0 immediately, no loadPC pulse follows.
REQ-037 With MC_CTRL_PERF_CNT_EN, CNT_W=4: 17 NOP instructions (opcode 0000000) -> instr_cnt=1 after wrap; without macro instr_cnt stays 0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle RISC-V-style control FSM (IF/ID/EX/MEM/WB/ERR).
//
// Captures the instruction on the IF->ID edge into an internal instruction
// register and decodes only from that register. The datapath controls
// (MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg, loadPC, PCSrc, ALUCtrl) are
// functions of the current state and the instruction register, so the
// asynchronous reset silences every strobe immediately.
//
// Parameters
//   MEM_TIMEOUT  MEM cycles waited for mem_ready before entering ERR (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instr[31:0]       instruction word, sampled in IF
//   zero, lt          ALU flags, sampled in EX for the branch decision
//   mem_ready         data-memory completion, sampled in MEM
//   MemRead .. PCSrc  datapath control strobes
//   ALUCtrl[3:0]      ALU operation select
//   state[2:0]        IF 000, ID 001, EX 010, MEM 011, WB 100, ERR 101
//   mem_err           sticky memory-timeout flag (cleared only by rst)
//   instr_cnt         retired-instruction count
//
// Build option
//   MC_CTRL_PERF_CNT_EN  when defined, instr_cnt counts loadPC pulses
//                        (wrapping); otherwise it is tied to zero and no
//                        counter register exists.

module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             loadPC,
    output logic             PCSrc,
    output logic [3:0]       ALUCtrl,
    output logic [2:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_cnt
);

    // State encoding (visible on the state port).
    localparam logic [2:0] StIf  = 3'b000;
    localparam logic [2:0] StId  = 3'b001;
    localparam logic [2:0] StEx  = 3'b010;
    localparam logic [2:0] StMem = 3'b011;
    localparam logic [2:0] StWb  = 3'b100;
    localparam logic [2:0] StErr = 3'b101;

    // Opcodes.
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;

    // ALU operation codes.
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0100;
    localparam logic [3:0] AluXor = 4'b0101;
    localparam logic [3:0] AluLsr = 4'b1000;
    localparam logic [3:0] AluLsl = 4'b1001;
    localparam logic [3:0] AluAsr = 4'b1010;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // One extra bit so the incremented wait count can be compared without wrap.
    localparam logic [8:0] TimeoutVal = 9'(MEM_TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  wait_q, wait_d;
    logic        br_q, br_d;
    logic        err_q, err_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_load, is_store, is_branch, is_reg, is_imm;
    logic        br_cond;
    logic [3:0]  alu_dec;
    logic [8:0]  wait_inc;
    logic        in_decode, in_exec;

    // Register-index fields are not needed by the controller.
    logic unused_ir;
    assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

    // ------------------------------------------------------------------
    // Instruction-register decode
    // ------------------------------------------------------------------
    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_reg    = (opcode == OpReg);
    assign is_imm    = (opcode == OpImm);

    always_comb begin
        alu_dec = AluAnd;
        case (opcode)
            OpLoad, OpStore: alu_dec = AluAdd;
            OpBranch:        alu_dec = AluSub;
            OpReg: begin
                case ({funct7, funct3})
                    {F7Base, 3'b000}: alu_dec = AluAdd;
                    {F7Alt,  3'b000}: alu_dec = AluSub;
                    {F7Base, 3'b001}: alu_dec = AluLsl;
                    {F7Base, 3'b010}: alu_dec = AluSlt;
                    {F7Base, 3'b100}: alu_dec = AluXor;
                    {F7Base, 3'b101}: alu_dec = AluLsr;
                    {F7Alt,  3'b101}: alu_dec = AluAsr;
                    {F7Base, 3'b110}: alu_dec = AluOr;
                    {F7Base, 3'b111}: alu_dec = AluAnd;
                    default:          alu_dec = AluAnd;
                endcase
            end
            OpImm: begin
                case (funct3)
                    3'b000:  alu_dec = AluAdd;
                    3'b001:  alu_dec = AluLsl;
                    3'b010:  alu_dec = AluSlt;
                    3'b100:  alu_dec = AluXor;
                    3'b110:  alu_dec = AluOr;
                    3'b111:  alu_dec = AluAnd;
                    3'b101: begin
                        // Shift-right flavour is selected by funct7.
                        if (funct7 == F7Base) begin
                            alu_dec = AluLsr;
                        end else if (funct7 == F7Alt) begin
                            alu_dec = AluAsr;
                        end else begin
                            alu_dec = AluAnd;
                        end
                    end
                    default: alu_dec = AluAnd;
                endcase
            end
            default: alu_dec = AluAnd;
        endcase
    end

    // Branch condition from the live EX-stage ALU flags.
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = zero;
            3'b001:  br_cond = ~zero;
            3'b100:  br_cond = lt;
            3'b101:  br_cond = ~lt;
            default: br_cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign wait_inc = {1'b0, wait_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        br_d    = br_q;
        err_d   = err_q;
        case (state_q)
            StIf: begin
                ir_d    = instr;
                state_d = StId;
            end
            StId: begin
                state_d = StEx;
            end
            StEx: begin
                br_d    = is_branch & br_cond;
                wait_d  = '0;
                state_d = (is_load || is_store) ? StMem : StWb;
            end
            StMem: begin
                // A completion on the timeout cycle still wins over the error.
                if (mem_ready) begin
                    state_d = StWb;
                end else if (wait_inc == TimeoutVal) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_inc[7:0];
                end
            end
            StWb: begin
                state_d = StIf;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIf;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIf;
            ir_q    <= '0;
            wait_q  <= '0;
            br_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            br_q    <= br_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Control outputs (Moore: state + instruction register only)
    // ------------------------------------------------------------------
    assign in_exec   = (state_q == StEx) || (state_q == StMem) || (state_q == StWb);
    assign in_decode = (state_q == StId) || in_exec;

    always_comb begin
        ALUCtrl  = in_decode ? alu_dec : AluAnd;
        ALUSrc   = in_exec & (is_load | is_store | is_imm);
        MemtoReg = in_exec & is_load;
        MemRead  = (state_q == StMem) & is_load;
        MemWrite = (state_q == StMem) & is_store;
        RegWrite = (state_q == StWb) & (is_load | is_reg | is_imm);
        loadPC   = (state_q == StWb);
        PCSrc    = (state_q == StWb) & br_q;
    end

    assign state   = state_q;
    assign mem_err = err_q;

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = loadPC ? (cnt_q + CNT_W'(1)) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed cases plus a random
// instruction stream, each instruction checked cycle by cycle against a
// reference built from the instruction class, flag values and memory waits.

module tb_mc_ctrl_fsm;

    localparam int unsigned MemTimeout = 15;
    localparam int unsigned CntW       = 4;

    localparam logic [2:0] SIf  = 3'd0;
    localparam logic [2:0] SId  = 3'd1;
    localparam logic [2:0] SEx  = 3'd2;
    localparam logic [2:0] SMem = 3'd3;
    localparam logic [2:0] SWb  = 3'd4;
    localparam logic [2:0] SErr = 3'd5;

    localparam logic [31:0] IAdd = 32'h002081B3;
    localparam logic [31:0] ILw  = 32'h0000A183;
    localparam logic [31:0] ISw  = 32'h0020A023;
    localparam logic [31:0] IBne = 32'h00209463;
    localparam logic [31:0] IBlt = 32'h0020C463;

    logic            clk;
    logic            rst;
    logic [31:0]     instr;
    logic            zero;
    logic            lt;
    logic            mem_ready;
    logic            MemRead;
    logic            MemWrite;
    logic            RegWrite;
    logic            ALUSrc;
    logic            MemtoReg;
    logic            loadPC;
    logic            PCSrc;
    logic [3:0]      ALUCtrl;
    logic [2:0]      state;
    logic            mem_err;
    logic [CntW-1:0] instr_cnt;

    int unsigned total   = 0;
    int unsigned bad     = 0;
    int unsigned retired = 0;

    mc_ctrl_fsm #(
        .MEM_TIMEOUT(MemTimeout),
        .CNT_W      (CntW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .zero     (zero),
        .lt       (lt),
        .mem_ready(mem_ready),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .loadPC   (loadPC),
        .PCSrc    (PCSrc),
        .ALUCtrl  (ALUCtrl),
        .state    (state),
        .mem_err  (mem_err),
        .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] obs_vec;
    assign obs_vec = {MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg, loadPC, PCSrc,
                      ALUCtrl, state, mem_err};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ALU op straight from the mnemonic table.
    function automatic logic [3:0] m_alu(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        if (op == 7'b0000011 || op == 7'b0100011) return 4'b0010;
        if (op == 7'b1100011) return 4'b0110;
        if (op == 7'b0110011) begin
            if (f7 == 7'b0000000) begin
                case (f3)
                    3'd0: return 4'b0010;
                    3'd1: return 4'b1001;
                    3'd2: return 4'b0100;
                    3'd4: return 4'b0101;
                    3'd5: return 4'b1000;
                    3'd6: return 4'b0001;
                    default: return 4'b0000;
                endcase
            end
            if (f7 == 7'b0100000 && f3 == 3'd0) return 4'b0110;
            if (f7 == 7'b0100000 && f3 == 3'd5) return 4'b1010;
            return 4'b0000;
        end
        if (op == 7'b0010011) begin
            case (f3)
                3'd0: return 4'b0010;
                3'd1: return 4'b1001;
                3'd2: return 4'b0100;
                3'd4: return 4'b0101;
                3'd6: return 4'b0001;
                3'd5: begin
                    if (f7 == 7'b0000000) return 4'b1000;
                    if (f7 == 7'b0100000) return 4'b1010;
                    return 4'b0000;
                end
                default: return 4'b0000;
            endcase
        end
        return 4'b0000;
    endfunction

    function automatic logic m_taken(input logic [31:0] i, input logic z, input logic l);
        if (i[6:0] != 7'b1100011) return 1'b0;
        case (i[14:12])
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            default: return 1'b0;
        endcase
    endfunction

    // Expected control bundle for instruction i while the FSM is in st.
    function automatic logic [14:0] exp_vec(input logic [2:0] st, input logic [31:0] i,
                                            input logic taken);
        logic lw, sw, rt, it, act, late;
        lw   = (i[6:0] == 7'b0000011);
        sw   = (i[6:0] == 7'b0100011);
        rt   = (i[6:0] == 7'b0110011);
        it   = (i[6:0] == 7'b0010011);
        act  = st inside {SId, SEx, SMem, SWb};
        late = st inside {SEx, SMem, SWb};
        return {st == SMem && lw, st == SMem && sw, st == SWb && (lw || rt || it),
                late && (lw || sw || it), late && lw, st == SWb, st == SWb && taken,
                act ? m_alu(i) : 4'b0000, st, st == SErr};
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef MC_CTRL_PERF_CNT_EN
        return 32'(retired % (32'd1 << CntW));
`else
        return 32'd0;
`endif
    endfunction

    // Asserts rst mid-cycle and checks the asynchronous effect; leaves rst high.
    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        check_eq(tag, 32'(obs_vec), 32'(exp_vec(SIf, 32'd0, 1'b0)));
        retired = 0;
        check_eq({tag, "_cnt"}, 32'(instr_cnt), exp_cnt());
    endtask

    // Runs one instruction; waits = MEM cycles with mem_ready low before it
    // rises; abort_k >= 0 asserts rst in that MEM cycle.
    task automatic run_instr(input logic [31:0] i, input logic z, input logic l,
                             input int waits, input int abort_k);
        logic mem_op, taken;
        mem_op = (i[6:0] == 7'b0000011) || (i[6:0] == 7'b0100011);
        taken  = m_taken(i, z, l);
        @(negedge clk);
        rst = 1'b0;
        check_eq("if", 32'(obs_vec), 32'(exp_vec(SIf, i, taken)));
        check_eq("if_cnt", 32'(instr_cnt), exp_cnt());
        instr     = i;
        zero      = 1'($urandom);
        lt        = 1'($urandom);
        mem_ready = 1'($urandom);
        @(negedge clk);
        check_eq("id", 32'(obs_vec), 32'(exp_vec(SId, i, taken)));
        instr = $urandom;
        @(negedge clk);
        check_eq("ex", 32'(obs_vec), 32'(exp_vec(SEx, i, taken)));
        zero = z;
        lt   = l;
        if (mem_op) begin
            for (int k = 0; k < int'(MemTimeout); k++) begin
                @(negedge clk);
                check_eq("mem", 32'(obs_vec), 32'(exp_vec(SMem, i, taken)));
                zero = 1'($urandom);
                lt   = 1'($urandom);
                if (k == abort_k) begin
                    do_reset("abort");
                    return;
                end
                mem_ready = (k >= waits);
                if (mem_ready) break;
                if (k + 1 == int'(MemTimeout)) begin
                    for (int e = 0; e < 3; e++) begin
                        @(negedge clk);
                        check_eq("err", 32'(obs_vec), 32'(exp_vec(SErr, i, taken)));
                        mem_ready = 1'($urandom);
                        instr     = $urandom;
                        zero      = 1'($urandom);
                        lt        = 1'($urandom);
                    end
                    do_reset("err_rst");
                    return;
                end
            end
        end
        @(negedge clk);
        check_eq("wb", 32'(obs_vec), 32'(exp_vec(SWb, i, taken)));
        check_eq("wb_cnt", 32'(instr_cnt), exp_cnt());
        retired++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[6:0] = 7'b0000011;
            1: r[6:0] = 7'b0100011;
            2: r[6:0] = 7'b1100011;
            3: r[6:0] = 7'b0110011;
            4: r[6:0] = 7'b0010011;
            5: r = r;
            default: r = 32'd0;
        endcase
        if ($urandom_range(0, 2) != 0) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000
                                                                               : 7'b0000000;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int ab;
        rst       = 1'b1;
        instr     = 32'd0;
        zero      = 1'b0;
        lt        = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset", 32'(obs_vec), 32'(exp_vec(SIf, 32'd0, 1'b0)));
        check_eq("reset_cnt", 32'(instr_cnt), 32'd0);

        run_instr(IAdd, 1'b0, 1'b0, 0, -1);
        run_instr(ILw, 1'b0, 1'b0, 3, -1);
        run_instr(IBne, 1'b0, 1'b0, 0, -1);
        run_instr(IBne, 1'b1, 1'b0, 0, -1);
        run_instr(IBlt, 1'b0, 1'b1, 0, -1);
        run_instr(ISw, 1'b0, 1'b0, 1000, -1);
        run_instr(ISw, 1'b0, 1'b0, int'(MemTimeout) - 1, -1);
        run_instr(ISw, 1'b0, 1'b0, 1000, 4);
        for (int n = 0; n < 17; n++) run_instr(32'd0, 1'b0, 1'b0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MemTimeout - 1, MemTimeout + 3))
                                             : int'($urandom_range(0, 4));
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(rand_instr(), 1'($urandom), 1'($urandom), w, ab);
        end
        run_instr(32'd0, 1'b0, 1'b0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
